// File: rtl/lc3b_data_mem_responder.sv
// Data-memory responder for the LC-3b pipeline: word-addressed 16-bit store with
// byte-enabled writes, answering each request after LATENCY cycles with a resp pulse.
module lc3b_data_mem_responder #(
   parameter int unsigned ADDR_BITS = 8,
   parameter int unsigned LATENCY   = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_byte_enable,
   input  logic [15:0] mem_address,
   input  logic [15:0] mem_wdata,
   output logic        mem_resp,
   output logic [15:0] mem_rdata,
   output logic        mem_err
);

   localparam int unsigned DEPTH = 2 ** ADDR_BITS;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned IDX_W = ADDR_BITS;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               rd_q, rd_d;
   logic               wr_q, wr_d;
   logic [1:0]         be_q, be_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [15:0]        wdata_q, wdata_d;
   logic               resp_q, resp_d;
   logic [15:0]        rdata_q, rdata_d;
   logic               err_q, err_d;

   logic [15:0]        store [DEPTH];

   // Operation selected for the edge that enters RESP (live inputs when LATENCY=1)
   logic               enter_resp_c;
   logic               op_rd_c, op_wr_c;
   logic [1:0]         op_be_c;
   logic [IDX_W-1:0]   op_idx_c;
   logic [15:0]        op_wdata_c;
   logic               wr_en_c;

   logic [IDX_W-1:0]   in_idx_c;
   logic               unused_addr_c;

   assign in_idx_c      = mem_address[ADDR_BITS:1];
   assign unused_addr_c = ^{mem_address[15:ADDR_BITS+1], mem_address[0]};

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rd_d         = rd_q;
      wr_d         = wr_q;
      be_d         = be_q;
      idx_d        = idx_q;
      wdata_d      = wdata_q;
      resp_d       = 1'b0;
      err_d        = 1'b0;
      rdata_d      = rdata_q;
      enter_resp_c = 1'b0;
      op_rd_c      = rd_q;
      op_wr_c      = wr_q;
      op_be_c      = be_q;
      op_idx_c     = idx_q;
      op_wdata_c   = wdata_q;
      wr_en_c      = 1'b0;

      case (state_q)
         IDLE: begin
            if (mem_read || mem_write) begin
               rd_d    = mem_read;
               wr_d    = mem_write;
               be_d    = mem_byte_enable;
               idx_d   = in_idx_c;
               wdata_d = mem_wdata;
               cnt_d   = CNT_W'(LATENCY - 1);
               if (LATENCY == 1) begin
                  state_d      = RESP;
                  enter_resp_c = 1'b1;
                  op_rd_c      = mem_read;
                  op_wr_c      = mem_write;
                  op_be_c      = mem_byte_enable;
                  op_idx_c     = in_idx_c;
                  op_wdata_c   = mem_wdata;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d      = RESP;
               enter_resp_c = 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Read+write together is a protocol error and is served as a plain read
      if (enter_resp_c) begin
         resp_d = 1'b1;
         err_d  = op_rd_c && op_wr_c;
         if (op_rd_c) begin
            rdata_d = store[op_idx_c];
         end else begin
            wr_en_c = op_wr_c;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         be_q    <= 2'b00;
         idx_q   <= '0;
         wdata_q <= 16'h0000;
         resp_q  <= 1'b0;
         rdata_q <= 16'h0000;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         be_q    <= be_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         resp_q  <= resp_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Store is never reset; writes are suppressed while reset is held
   always_ff @(posedge clk) begin
      if (wr_en_c && !reset) begin
         if (op_be_c[0]) store[op_idx_c][7:0]  <= op_wdata_c[7:0];
         if (op_be_c[1]) store[op_idx_c][15:8] <= op_wdata_c[15:8];
      end
   end

   assign mem_resp  = resp_q;
   assign mem_rdata = rdata_q;
   assign mem_err   = err_q;

endmodule
